// File: rtl/regfile_writeback_if.sv
// Write-back bus bundle: ALU result, load handshake, register-file write port.
// WB_STATS_EN adds the conflict_count statistic to the bundle.
interface regfile_writeback_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int LD_DEPTH   = 4
);
  localparam int CW   = $clog2(LD_DEPTH) + 1;
  localparam int NREG = 1 << ADDR_WIDTH;

  logic                  alu_valid;
  logic [ADDR_WIDTH-1:0] alu_addr;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  ld_valid;
  logic                  ld_ready;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic [NREG-1:0]       pending_mask;
  logic [CW-1:0]         ld_count;
`ifdef WB_STATS_EN
  logic [15:0]           conflict_count;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output ld_valid, ld_addr, ld_data,
    input  ld_ready,
    input  write_enable, write_addr, write_data,
    input  pending_mask, ld_count, conflict_count
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  ld_valid, ld_addr, ld_data,
    output ld_ready,
    output write_enable, write_addr, write_data,
    output pending_mask, ld_count, conflict_count
  );
`else
  modport master (
    output alu_valid, alu_addr, alu_data,
    output ld_valid, ld_addr, ld_data,
    input  ld_ready,
    input  write_enable, write_addr, write_data,
    input  pending_mask, ld_count
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  ld_valid, ld_addr, ld_data,
    output ld_ready,
    output write_enable, write_addr, write_data,
    output pending_mask, ld_count
  );
`endif
endinterface

// File: rtl/regfile_writeback.sv
// Write-back arbiter: ALU results beat queued loads onto the single RF write
// port. Optional WB_STATS_EN macro adds a saturating ALU/load conflict counter.
module regfile_writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int LD_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  regfile_writeback_if.slave bus
);
  localparam int PW   = $clog2(LD_DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  addr_t               ent_addr_q [LD_DEPTH];
  addr_t               ent_addr_d [LD_DEPTH];
  data_t               ent_data_q [LD_DEPTH];
  data_t               ent_data_d [LD_DEPTH];
  logic [LD_DEPTH-1:0] live_q, live_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [NREG-1:0]     pend_q, pend_d;
  logic                we_q, we_d;
  addr_t               waddr_q, waddr_d;
  data_t               wdata_q, wdata_d;

  logic full;
  logic push;
  logic pop;
  logic alu_issue;
  logic head_valid;
  logic head_live;
  logic ld_issue;

  // Arbitration: ALU first; a killed head drains whenever it reaches the head
  always_comb begin
    full       = (count_q == CW'(LD_DEPTH));
    push       = bus.ld_valid && !full;
    alu_issue  = bus.alu_valid && (bus.alu_addr != '0);
    head_valid = (count_q != '0);
    head_live  = head_valid && live_q[rd_ptr_q];
    ld_issue   = head_live && !alu_issue;
    pop        = head_valid && (!head_live || !alu_issue);
  end

  // FIFO next state: kill entries shadowed by the younger ALU write
  always_comb begin
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    live_d     = live_q;
    for (int i = 0; i < LD_DEPTH; i++) begin
      if (alu_issue && ent_addr_q[i] == bus.alu_addr) begin
        live_d[i] = 1'b0;
      end
    end
    if (pop) begin
      live_d[rd_ptr_q] = 1'b0;
    end
    if (push) begin
      ent_addr_d[wr_ptr_q] = bus.ld_addr;
      ent_data_d[wr_ptr_q] = bus.ld_data;
      live_d[wr_ptr_q]     = (bus.ld_addr != '0) &&
                             !(alu_issue && bus.ld_addr == bus.alu_addr);
    end
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // Pending mask tracks the live entries of the next FIFO state
  always_comb begin
    pend_d = '0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      if (live_d[i]) begin
        pend_d[ent_addr_d[i]] = 1'b1;
      end
    end
    pend_d[0] = 1'b0;
  end

  // Write port next state; address and data hold when idle
  always_comb begin
    we_d    = alu_issue || ld_issue;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (1'b1)
      alu_issue: begin
        waddr_d = bus.alu_addr;
        wdata_d = bus.alu_data;
      end
      ld_issue: begin
        waddr_d = ent_addr_q[rd_ptr_q];
        wdata_d = ent_data_q[rd_ptr_q];
      end
      default: ;
    endcase
  end

  // Control state, cleared by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      live_q   <= live_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Entry payload storage; validity lives in live_q/count_q
  always_ff @(posedge clk) begin
    ent_addr_q <= ent_addr_d;
    ent_data_q <= ent_data_d;
  end

  assign bus.ld_ready     = !full;
  assign bus.ld_count     = count_q;
  assign bus.pending_mask = pend_q;
  assign bus.write_enable = we_q;
  assign bus.write_addr   = waddr_q;
  assign bus.write_data   = wdata_q;

`ifdef WB_STATS_EN
  logic [15:0] conflict_q, conflict_d;

  // Count cycles where a live load was ready but the ALU took the port
  always_comb begin
    conflict_d = conflict_q;
    if (head_live && alu_issue && conflict_q != 16'hFFFF) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  // Statistic register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      conflict_q <= '0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign bus.conflict_count = conflict_q;
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback.
// Hand-computed expectations per cycle, immediate assertions at each check.
module tb_regfile_writeback;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int wcnt [32];
  logic [31:0] wlast [32];
  int zero_wr = 0;
  int base;
`ifdef WB_STATS_EN
  logic [15:0] cc0;
`endif

  regfile_writeback_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .LD_DEPTH(4)) wb();

  regfile_writeback #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .LD_DEPTH(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(wb.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n && wb.write_enable) begin
      wcnt[wb.write_addr]++;
      wlast[wb.write_addr] = wb.write_data;
      if (wb.write_addr == 5'd0) zero_wr++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wb.alu_valid = 1'b0;
    wb.alu_addr  = '0;
    wb.alu_data  = '0;
    wb.ld_valid  = 1'b0;
    wb.ld_addr   = '0;
    wb.ld_data   = '0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      wcnt[i]  = 0;
      wlast[i] = '0;
    end
    idle();
    step();
    step();
    chk("rst_we", wb.write_enable, 0);
    chk("rst_addr", wb.write_addr, 0);
    chk("rst_data", wb.write_data, 0);
    chk("rst_cnt", wb.ld_count, 0);
    chk("rst_rdy", wb.ld_ready, 1);
    chk("rst_mask", wb.pending_mask, 0);
    reset_n = 1'b1;
    step();

    // ALU single write, latency 1
    wb.alu_valid = 1'b1;
    wb.alu_addr  = 5'd5;
    wb.alu_data  = 32'hDEADBEEF;
    step();
    idle();
    chk("alu_we", wb.write_enable, 1);
    chk("alu_addr", wb.write_addr, 5);
    chk("alu_data", wb.write_data, 32'hDEADBEEF);
    step();
    chk("alu_we_off", wb.write_enable, 0);
    chk("alu_hold", wb.write_data, 32'hDEADBEEF);

    // ALU priority over a queued load
`ifdef WB_STATS_EN
    cc0 = wb.conflict_count;
`endif
    wb.alu_valid = 1'b1;
    wb.alu_addr  = 5'd1;
    wb.alu_data  = 32'h11;
    wb.ld_valid  = 1'b1;
    wb.ld_addr   = 5'd7;
    wb.ld_data   = 32'h1234;
    step();
    wb.ld_valid = 1'b0;
    chk("s3_a1", wb.write_addr, 1);
    chk("s3_m1", wb.pending_mask, 32'h80);
    chk("s3_c1", wb.ld_count, 1);
    wb.alu_addr = 5'd2;
    wb.alu_data = 32'h22;
    step();
    chk("s3_a2", wb.write_addr, 2);
    chk("s3_m2", wb.pending_mask, 32'h80);
    wb.alu_addr = 5'd3;
    wb.alu_data = 32'h33;
    step();
    idle();
    chk("s3_a3", wb.write_addr, 3);
    chk("s3_m3", wb.pending_mask, 32'h80);
    step();
    chk("s3_we4", wb.write_enable, 1);
    chk("s3_a4", wb.write_addr, 7);
    chk("s3_d4", wb.write_data, 32'h1234);
    chk("s3_m4", wb.pending_mask, 0);
    chk("s3_c4", wb.ld_count, 0);
`ifdef WB_STATS_EN
    chk("s3_conf", 64'(wb.conflict_count - cc0), 2);
`endif
    step();
    chk("s3_we5", wb.write_enable, 0);

    // Fill FIFO under ALU pressure, then drain in order
    wb.alu_valid = 1'b1;
    wb.alu_addr  = 5'd20;
    wb.ld_valid  = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wb.ld_addr  = 5'(k);
      wb.ld_data  = 32'(100 + k);
      wb.alu_data = 32'(k);
      chk("s4_rdy", wb.ld_ready, 1);
      step();
      chk("s4_cnt", wb.ld_count, 64'(k));
    end
    wb.ld_addr = 5'd5;
    wb.ld_data = 32'd105;
    chk("s4_full", wb.ld_ready, 0);
    step();
    chk("s4_held", wb.ld_count, 4);
    chk("s4_m", wb.pending_mask, 32'h1E);
    wb.alu_valid = 1'b0;
    step();
    chk("s4_a1", wb.write_addr, 1);
    chk("s4_d1", wb.write_data, 101);
    chk("s4_c1", wb.ld_count, 3);
    chk("s4_r1", wb.ld_ready, 1);
    chk("s4_m1", wb.pending_mask, 32'h1C);
    step();
    wb.ld_valid = 1'b0;
    chk("s4_a2", wb.write_addr, 2);
    chk("s4_c2", wb.ld_count, 3);
    chk("s4_m2", wb.pending_mask, 32'h38);
    for (int k = 3; k <= 5; k++) begin
      step();
      chk("s4_we", wb.write_enable, 1);
      chk("s4_ak", wb.write_addr, 64'(k));
      chk("s4_dk", wb.write_data, 64'(100 + k));
      chk("s4_ck", wb.ld_count, 64'(5 - k));
    end
    step();
    chk("s4_idle", wb.write_enable, 0);
    chk("s4_mask0", wb.pending_mask, 0);

    // Younger ALU write kills queued load to same register
    base = wcnt[9];
    wb.alu_valid = 1'b1;
    wb.alu_addr  = 5'd20;
    wb.alu_data  = 32'h5;
    wb.ld_valid  = 1'b1;
    wb.ld_addr   = 5'd9;
    wb.ld_data   = 32'h1;
    step();
    wb.ld_valid = 1'b0;
    chk("s5_m", wb.pending_mask, 32'h200);
    wb.alu_addr = 5'd9;
    wb.alu_data = 32'hAA;
    step();
    idle();
    chk("s5_a", wb.write_addr, 9);
    chk("s5_d", wb.write_data, 32'hAA);
    chk("s5_m0", wb.pending_mask, 0);
    chk("s5_c", wb.ld_count, 1);
    step();
    chk("s5_drain", wb.ld_count, 0);
    chk("s5_we", wb.write_enable, 0);
    step();
    chk("s5_once", 64'(wcnt[9] - base), 1);
    chk("s5_last", wlast[9], 32'hAA);

    // Register zero from both sources
    wb.alu_valid = 1'b1;
    wb.alu_addr  = 5'd0;
    wb.alu_data  = 32'h55;
    wb.ld_valid  = 1'b1;
    wb.ld_addr   = 5'd0;
    wb.ld_data   = 32'h66;
    step();
    idle();
    chk("s6_we", wb.write_enable, 0);
    chk("s6_c1", wb.ld_count, 1);
    chk("s6_m", wb.pending_mask, 0);
    step();
    chk("s6_c0", wb.ld_count, 0);
    chk("s6_we2", wb.write_enable, 0);
    step();
    chk("s6_we3", wb.write_enable, 0);

    // Reset mid-stream with three loads queued
    wb.alu_valid = 1'b1;
    wb.alu_addr  = 5'd20;
    wb.ld_valid  = 1'b1;
    for (int k = 11; k <= 13; k++) begin
      wb.ld_addr = 5'(k);
      wb.ld_data = 32'(k);
      step();
    end
    chk("s1_q3", wb.ld_count, 3);
    base = wcnt[11] + wcnt[12] + wcnt[13];
    reset_n = 1'b0;
    #1;
    chk("s1_we", wb.write_enable, 0);
    chk("s1_cnt", wb.ld_count, 0);
    chk("s1_rdy", wb.ld_ready, 1);
    chk("s1_mask", wb.pending_mask, 0);
    idle();
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) step();
    chk("s1_lost", 64'(wcnt[11] + wcnt[12] + wcnt[13] - base), 0);
    chk("s1_cnt2", wb.ld_count, 0);
    chk("zero_wr", 64'(zero_wr), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
